time_entry_loader: RTL and testbench
====================================

// Module: time_entry_loader
// PURPOSE
// Upstream controller for the BCD down-counter chain (mm:ss, four digits).
// Collects keypad digits into a 4-digit BCD entry buffer and validates it on start.
// Then drives the counters' active-low parallel load, and issues one-cycle count-enable ticks at 1 Hz.
// Stops ticking once the downstream chain reports all-zero.
// PARAMETERS
// TICK_DIV     50_000_000  clk cycles per en tick (1 Hz at 50 MHz); >= 2
// LOAD_CYCLES  2           cycles loadn is held low during load; >= 1
// PORTS
// clk         in   1   system clock, rising edge
// clr         in   1   asynchronous reset, active-high
// key_valid   in   1   one-cycle strobe, key_code valid
// key_code    in   4   keypad code; 0-9 digits, 10-15 ignored
// start       in   1   one-cycle start request
// cancel      in   1   one-cycle cancel/clear request
// count_zero  in   1   high when all four downstream counters read 0
// door_open   in   1   door sensor, high = open (only with DOOR_INTERLOCK_EN)
// entry       out  16  entry buffer {min_t, min_o, sec_t, sec_o}, for display
// load_data   out  16  value driven to counter data inputs, same packing
// loadn       out  1   active-low load to counters
// en          out  1   one-cycle count-enable tick to counter chain
// running     out  1   high in LOAD/RUN (and PAUSE)
// done        out  1   high in DONE
// err         out  1   one-cycle pulse on rejected start
// BEHAVIOUR
// - Reset (async, clr=1): state IDLE; entry=0, load_data=0, loadn=1, en=0, running=0, done=0, err=0; tick counter=0.
// - All outputs are registered. clr deasserts into IDLE on next clk.
// - States: IDLE, LOAD, RUN, DONE (+PAUSE with macro).
// - IDLE, key_valid & key_code<=9: entry <= {entry[11:0], key_code}.
//   A 5th digit drops the oldest digit. key_code>9 is ignored.
// - IDLE, cancel: entry <= 0. cancel has priority over start and key_valid in the same cycle.
// - IDLE, start: the entry value before any same-cycle key is used; the same-cycle key is discarded.
//   - entry==0 -> err pulse, stay in IDLE.
//   - entry[7:4]>5 (sec tens 6-9) -> err pulse, stay in IDLE.
//   - Otherwise load_data<=entry, go to LOAD.
// - LOAD: loadn=0 for exactly LOAD_CYCLES cycles, starting the cycle after start.
//   load_data is held stable. Then loadn=1 and the block enters RUN with tick counter=0.
// - RUN: tick counter counts 0..TICK_DIV-1 and wraps.
//   - At the wrap cycle: if count_zero=1 -> no en, go to DONE. Else en=1 for that one cycle.
//   - First en occurs TICK_DIV cycles after RUN entry. key_valid and start are ignored.
// - cancel in LOAD/RUN: go to IDLE the next cycle; loadn=1, en=0 that cycle.
//   Tick counter=0; entry is cleared.
// - DONE: done=1, en=0. Held until any of cancel, start or key_valid occurs, then go to IDLE with entry=0.
//   The exiting key is discarded.
// - en and loadn=0 are never asserted in the same cycle.
// - Reset mid-LOAD/RUN returns loadn=1 and en=0 immediately (async).
// CONFIGURATION
// - DOOR_INTERLOCK_EN defined:
//   - door_open port exists.
//   - start with door_open=1 -> err pulse; no state change.
//   - RUN with door_open=1 -> PAUSE: tick counter frozen, en=0, running=1.
//   - PAUSE + start with door closed -> RUN, resuming from the frozen count.
//   - PAUSE + cancel -> IDLE.
//   - door_open in LOAD is sampled only after LOAD completes.
// - DOOR_INTERLOCK_EN undefined: door_open port and PAUSE state absent; the door has no effect.
// TESTING (TICK_DIV=4, LOAD_CYCLES=2)
// - Keys 1,3,0 then 12: entry=16'h0130. Start: loadn low 2 cycles, load_data=16'h0130, then en every 4th cycle.
// - Keys 1,2,3,4,5: entry=16'h2345. Cancel then start: entry=0, err pulse, stay IDLE.
// - Keys 1,7,0 (entry 16'h0170), start: err=1 one cycle, loadn stays 1, state IDLE.
// - RUN with count_zero forced 1 before third tick: en seen twice, then done=1, en=0. key_valid -> IDLE.
// - start+cancel same cycle in IDLE with entry 16'h0045: entry=0, no load. cancel mid-RUN: en=0 the next cycle.
// - [DOOR_INTERLOCK_EN] door_open=1 mid-RUN for 10 cycles: no en. Close + start: next en is 4 minus the count elapsed before the pause.

Source files
------------

// File: rtl/time_entry_loader.sv
// Keypad entry buffer and load/tick sequencer for a four-digit mm:ss BCD down-counter chain.
// Optional door interlock and PAUSE state are enabled by defining DOOR_INTERLOCK_EN.
module time_entry_loader #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int LOAD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        start,
    input  logic        cancel,
    input  logic        count_zero,
`ifdef DOOR_INTERLOCK_EN
    input  logic        door_open,
`endif
    output logic [15:0] entry,
    output logic [15:0] load_data,
    output logic        loadn,
    output logic        en,
    output logic        running,
    output logic        done,
    output logic        err
);

    // state | meaning
    // IDLE  | collecting keypad digits, waiting for start
    // LOAD  | loadn held low, load_data presented to the counters
    // RUN   | dividing clk down to one-cycle en ticks
    // DONE  | counters reached zero, waiting for any key/start/cancel
    // PAUSE | door opened during RUN, tick count frozen (interlock builds only)
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef DOOR_INTERLOCK_EN
    localparam logic [2:0] S_PAUSE = 3'd4;
`endif

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LOAD_INIT = LW'(LOAD_CYCLES - 1);

    logic [2:0]    state;
    logic [TW-1:0] tick_cnt;
    logic [LW-1:0] load_cnt;
    logic          entry_ok;

    assign entry_ok = (entry != 16'h0000) && (entry[7:4] <= 4'd5);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE;
            entry     <= 16'h0000;
            load_data <= 16'h0000;
            loadn     <= 1'b1;
            en        <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            tick_cnt  <= '0;
            load_cnt  <= '0;
        end else begin
            err <= 1'b0;
            en  <= 1'b0;
            // running is high exactly in LOAD/RUN/PAUSE, so it doubles as the abort qualifier
            if (cancel && running) begin
                state    <= S_IDLE;
                entry    <= 16'h0000;
                loadn    <= 1'b1;
                running  <= 1'b0;
                tick_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cancel) begin
                            entry <= 16'h0000;
                        end else if (start) begin
`ifdef DOOR_INTERLOCK_EN
                            if (door_open || !entry_ok) begin
`else
                            if (!entry_ok) begin
`endif
                                err <= 1'b1;
                            end else begin
                                load_data <= entry;
                                loadn     <= 1'b0;
                                load_cnt  <= LOAD_INIT;
                                running   <= 1'b1;
                                state     <= S_LOAD;
                            end
                        end else if (key_valid && (key_code <= 4'd9)) begin
                            entry <= {entry[11:0], key_code};
                        end
                    end
                    S_LOAD: begin
                        if (load_cnt == '0) begin
                            loadn    <= 1'b1;
                            tick_cnt <= '0;
                            state    <= S_RUN;
                        end else begin
                            load_cnt <= load_cnt - 1'b1;
                        end
                    end
                    S_RUN: begin
`ifdef DOOR_INTERLOCK_EN
                        if (door_open) begin
                            state <= S_PAUSE;
                        end else
`endif
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (count_zero) begin
                                running <= 1'b0;
                                done    <= 1'b1;
                                state   <= S_DONE;
                            end else begin
                                en <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`ifdef DOOR_INTERLOCK_EN
                    S_PAUSE: begin
                        if (start) begin
                            if (door_open) begin
                                err <= 1'b1;
                            end else begin
                                state <= S_RUN;
                            end
                        end
                    end
`endif
                    S_DONE: begin
                        if (cancel || start || key_valid) begin
                            done  <= 1'b0;
                            entry <= 16'h0000;
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        loadn   <= 1'b1;
                        running <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_time_entry_loader.sv
// Randomized self-checking bench for time_entry_loader (default build, TICK_DIV=4, LOAD_CYCLES=2).
// Reference: entry kept as a decimal number, output timing computed from cycle offsets.
module tb_time_entry_loader;

    localparam int TICK_DIV    = 4;
    localparam int LOAD_CYCLES = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        start;
    logic        cancel;
    logic        count_zero;
    logic [15:0] entry;
    logic [15:0] load_data;
    logic        loadn;
    logic        en;
    logic        running;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int m_val  = 0;   // model of the entry buffer as a decimal 0..9999

    time_entry_loader #(.TICK_DIV(TICK_DIV), .LOAD_CYCLES(LOAD_CYCLES)) dut (
        .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code),
        .start(start), .cancel(cancel), .count_zero(count_zero),
        .entry(entry), .load_data(load_data), .loadn(loadn), .en(en),
        .running(running), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit is_valid(input int v);
        return (v != 0) && ((v / 10) % 10 <= 5);
    endfunction

    // outputs after this reflect the edge that sampled the inputs driven beforehand
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input int code);
        key_valid = 1'b1;
        key_code  = 4'(code);
        step();
        key_valid = 1'b0;
        if (code <= 9) m_val = (m_val * 10 + code) % 10000;
    endtask

    task automatic enter_value(input int v);
        press_key(v / 1000 % 10);
        press_key(v / 100 % 10);
        press_key(v / 10 % 10);
        press_key(v % 10);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    function automatic int rand_valid();
        int v;
        v = $urandom_range(9999);
        while (!is_valid(v)) v = $urandom_range(9999);
        return v;
    endfunction

    task automatic test_reset();
        clr = 1'b1; key_valid = 1'b0; key_code = 4'd0; start = 1'b0;
        cancel = 1'b0; count_zero = 1'b0;
        #23;
        checks++;
        if ({entry, load_data, loadn, en, running, done, err} !== {32'h0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL reset: entry=%h load_data=%h loadn=%b en=%b running=%b done=%b err=%b",
                     entry, load_data, loadn, en, running, done, err);
        end
        clr = 1'b0;
        step();
        m_val = 0;
    endtask

    task automatic test_entry_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7) == 0) begin
                pulse_cancel();
                m_val = 0;
            end else begin
                press_key($urandom_range(15));
            end
            checks++;
            if (entry !== to_bcd(m_val)) begin
                errors++;
                $display("FAIL entry_rand[%0d]: got %h want %h", i, entry, to_bcd(m_val));
            end
        end
        pulse_cancel();
        m_val = 0;
    endtask

    task automatic test_load_run();
        press_key(1); press_key(3); press_key(0); press_key(12);
        checks++;
        if (entry !== 16'h0130) begin
            errors++;
            $display("FAIL entry_0130: got %h want 0130", entry);
        end
        pulse_start();
        for (int n = 0; n < 20; n++) begin
            checks++;
            if (loadn !== (n >= LOAD_CYCLES) ||
                en !== (n >= LOAD_CYCLES + TICK_DIV && (n - LOAD_CYCLES) % TICK_DIV == 0) ||
                load_data !== 16'h0130 || running !== 1'b1) begin
                errors++;
                $display("FAIL load_run[%0d]: loadn=%b en=%b load_data=%h running=%b", n, loadn, en,
                         load_data, running);
            end
            step();
        end
        pulse_cancel();
        m_val = 0;
        checks++;
        if ({en, loadn, running, entry} !== {3'b010, 16'h0}) begin
            errors++;
            $display("FAIL cancel_run: en=%b loadn=%b running=%b entry=%h want 0 1 0 0000",
                     en, loadn, running, entry);
        end
    endtask

    task automatic test_start_err();
        int v;
        press_key(1); press_key(2); press_key(3); press_key(4); press_key(5);
        checks++;
        if (entry !== 16'h2345) begin
            errors++;
            $display("FAIL entry_2345: got %h want 2345", entry);
        end
        pulse_cancel();
        m_val = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                press_key(1); press_key(7); press_key(0);
            end else if (i > 1) begin
                v = $urandom_range(99) * 100 + $urandom_range(6, 9) * 10 + $urandom_range(9);
                enter_value(v);
            end
            pulse_start();
            checks++;
            if (is_valid(m_val) || err !== 1'b1 || loadn !== 1'b1 || running !== 1'b0 ||
                entry !== to_bcd(m_val)) begin
                errors++;
                $display("FAIL start_err[%0d]: err=%b loadn=%b running=%b entry=%h model=%0d", i, err,
                         loadn, running, entry, m_val);
            end
            step();
            checks++;
            if (err !== 1'b0 || loadn !== 1'b1) begin
                errors++;
                $display("FAIL err_pulse[%0d]: err=%b loadn=%b want 0 1", i, err, loadn);
            end
            pulse_cancel();
            m_val = 0;
        end
    endtask

    task automatic test_same_cycle();
        int v;
        press_key(4); press_key(5);
        start = 1'b1; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        m_val = 0;
        step();
        checks++;
        if (entry !== 16'h0 || loadn !== 1'b1 || running !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_cancel: entry=%h loadn=%b running=%b err=%b", entry, loadn, running, err);
        end
        v = rand_valid();
        enter_value(v);
        start = 1'b1; key_valid = 1'b1; key_code = 4'd7;
        step();
        start = 1'b0; key_valid = 1'b0;
        checks++;
        if (load_data !== to_bcd(v) || entry !== to_bcd(v) || loadn !== 1'b0) begin
            errors++;
            $display("FAIL start_key: load_data=%h entry=%h loadn=%b want %h %h 0", load_data, entry,
                     loadn, to_bcd(v), to_bcd(v));
        end
        pulse_cancel();
        m_val = 0;
        checks++;
        if (loadn !== 1'b1 || running !== 1'b0 || entry !== 16'h0) begin
            errors++;
            $display("FAIL cancel_load: loadn=%b running=%b entry=%h", loadn, running, entry);
        end
    endtask

    task automatic test_done();
        int ens;
        ens = 0;
        enter_value(rand_valid());
        count_zero = 1'b0;
        pulse_start();
        for (int n = 0; n <= 14; n++) begin
            if (en === 1'b1) ens++;
            if (n == LOAD_CYCLES + 2 * TICK_DIV) count_zero = 1'b1;
            if (n < 14) step();
        end
        checks++;
        if (ens != 2 || done !== 1'b1 || en !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL done_entry: en_count=%0d done=%b en=%b running=%b want 2 1 0 0", ens, done,
                     en, running);
        end
        step(); step(); step();
        checks++;
        if (done !== 1'b1 || en !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: done=%b en=%b want 1 0", done, en);
        end
        count_zero = 1'b0;
        press_key(3);
        m_val = 0;
        checks++;
        if (done !== 1'b0 || entry !== 16'h0) begin
            errors++;
            $display("FAIL done_exit: done=%b entry=%h want 0 0000", done, entry);
        end
    endtask

    task automatic test_random_runs();
        int c;
        int v;
        for (int r = 0; r < 6; r++) begin
            v = rand_valid();
            enter_value(v);
            c = $urandom_range(30);
            pulse_start();
            for (int n = 0; n < c; n++) begin
                checks++;
                if (loadn !== (n >= LOAD_CYCLES) ||
                    en !== (n >= LOAD_CYCLES + TICK_DIV && (n - LOAD_CYCLES) % TICK_DIV == 0) ||
                    load_data !== to_bcd(v) || (en === 1'b1 && loadn === 1'b0)) begin
                    errors++;
                    $display("FAIL rand_run[%0d][%0d]: loadn=%b en=%b load_data=%h want data %h", r, n,
                             loadn, en, load_data, to_bcd(v));
                end
                step();
            end
            pulse_cancel();
            m_val = 0;
            checks++;
            if (en !== 1'b0 || loadn !== 1'b1 || running !== 1'b0 || entry !== 16'h0) begin
                errors++;
                $display("FAIL rand_cancel[%0d]: en=%b loadn=%b running=%b entry=%h", r, en, loadn,
                         running, entry);
            end
        end
    endtask

    task automatic test_async_reset();
        enter_value(rand_valid());
        pulse_start();
        #2 clr = 1'b1;
        #1;
        checks++;
        if (loadn !== 1'b1 || en !== 1'b0 || running !== 1'b0 || entry !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: loadn=%b en=%b running=%b entry=%h", loadn, en, running, entry);
        end
        #1 clr = 1'b0;
        m_val = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_entry_random();
        test_load_run();
        test_start_err();
        test_same_cycle();
        test_done();
        test_random_runs();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
